// File: rtl/dcache_access_unit_pkg.sv
// Shared LC-3b memory-access types.
//   lc3b_mem_op       : memory operation encoding presented on the core side
//   dau_state_e       : access-unit sequencing states
//   LINE_BITS_DEFAULT : default cache-line width in bits
package lc3b_types;

  localparam int LINE_BITS_DEFAULT = 128;

  typedef enum logic [2:0] {
    OP_LDR = 3'd0,
    OP_LDB = 3'd1,
    OP_STR = 3'd2,
    OP_STB = 3'd3,
    OP_LDI = 3'd4,
    OP_STI = 3'd5
  } lc3b_mem_op;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } dau_state_e;

  function automatic logic op_is_store(lc3b_mem_op op);
    return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  function automatic logic op_is_byte(lc3b_mem_op op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

  function automatic logic op_is_indirect(lc3b_mem_op op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/dcache_access_unit_if.sv
// Core-side request/response and cache-side bus of the data-cache access unit.
//   master : view of the access unit (drives ready/done/rdata and the dcache_* request)
//   slave  : view of the environment (core + cache)
interface dcache_access_unit_if #(
  parameter int LINE_BITS = lc3b_types::LINE_BITS_DEFAULT
) ();
  logic                   start;
  logic [2:0]             op;
  logic [15:0]            addr;
  logic [15:0]            wdata;
  logic                   ready;
  logic                   done;
  logic [15:0]            rdata;
  logic                   dcache_req;
  logic [15:0]            dcache_addr;
  logic                   dcache_wr_en;
  logic [LINE_BITS/8-1:0] dcache_wr_sel;
  logic [LINE_BITS-1:0]   dcache_wdata;
  logic                   dcache_resp;
  logic [LINE_BITS-1:0]   dcache_rdata;

  modport master (
    input  start, op, addr, wdata, dcache_resp, dcache_rdata,
    output ready, done, rdata, dcache_req, dcache_addr, dcache_wr_en,
           dcache_wr_sel, dcache_wdata
  );

  modport slave (
    output start, op, addr, wdata, dcache_resp, dcache_rdata,
    input  ready, done, rdata, dcache_req, dcache_addr, dcache_wr_en,
           dcache_wr_sel, dcache_wdata
  );
endinterface

// File: rtl/dcache_access_unit_lane_sel.sv
// line_lane_sel: extracts 16-bit/8-bit lanes from a cache line and places
// store data plus byte enables into a line.
//   line_rdata : line read from the cache
//   byte_off   : byte offset of the access within the line
//   is_byte    : byte access (else word access, byte_off[0] ignored)
//   wr_en      : store in progress; wr_sel/wr_line are zero otherwise
//   wdata      : raw store data
//   rd_word    : word lane at byte_off>>1
//   rd_byte    : byte lane at byte_off
//   wr_sel     : byte enables
//   wr_line    : line-placed store data
module line_lane_sel #(
  parameter  int LINE_BITS = 128,
  localparam int NBYTES    = LINE_BITS / 8,
  localparam int NWORDS    = LINE_BITS / 16,
  localparam int OFF       = $clog2(NBYTES)
) (
  input  logic [LINE_BITS-1:0] line_rdata,
  input  logic [OFF-1:0]       byte_off,
  input  logic                 is_byte,
  input  logic                 wr_en,
  input  logic [15:0]          wdata,
  output logic [15:0]          rd_word,
  output logic [7:0]           rd_byte,
  output logic [NBYTES-1:0]    wr_sel,
  output logic [LINE_BITS-1:0] wr_line
);

  logic [OFF-1:0] word_idx;
  assign word_idx = byte_off >> 1;

  always_comb begin
    rd_word = '0;
    rd_byte = '0;
    wr_sel  = '0;
    wr_line = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (word_idx == i[OFF-1:0]) rd_word = line_rdata[i*16 +: 16];
    end
    for (int j = 0; j < NBYTES; j++) begin
      if (byte_off == j[OFF-1:0]) rd_byte = line_rdata[j*8 +: 8];
    end
    if (wr_en) begin
      if (is_byte) begin
        // byte store data goes to every lane; only the enable selects the byte
        wr_line = {NBYTES{wdata[7:0]}};
        for (int j = 0; j < NBYTES; j++) begin
          if (byte_off == j[OFF-1:0]) wr_sel[j] = 1'b1;
        end
      end else begin
        for (int i = 0; i < NWORDS; i++) begin
          if (word_idx == i[OFF-1:0]) begin
            wr_line[i*16 +: 16] = wdata;
            wr_sel[i*2 +: 2]    = 2'b11;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dcache_access_unit.sv
// dcache_access_unit: sequences one LC-3b load/store (including the indirect
// LDI/STI pointer fetch) onto a line-wide data-cache port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : core request (start/op/addr/wdata -> ready/done/rdata) and the
//              cache request (dcache_req/addr/wr_en/wr_sel/wdata <- resp/rdata)
//
// state | meaning
// IDLE  | ready for a request
// PTR   | fetching the indirect pointer word
// MEM   | performing the data access
// DONE  | one-cycle completion pulse
module dcache_access_unit
  import lc3b_types::*;
#(
  parameter  int LINE_BITS = LINE_BITS_DEFAULT,
  localparam int NBYTES    = LINE_BITS / 8,
  localparam int OFF       = $clog2(NBYTES)
) (
  input logic              clk,
  input logic              rst,
  dcache_access_unit_if.master bus
);

  dau_state_e state_q, state_d;
  lc3b_mem_op op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic        wr_en;
  logic [15:0] rd_word;
  logic [7:0]  rd_byte;

  line_lane_sel #(.LINE_BITS(LINE_BITS)) u_lane_sel (
    .line_rdata (bus.dcache_rdata),
    .byte_off   (addr_q[OFF-1:0]),
    .is_byte    (op_is_byte(op_q)),
    .wr_en      (wr_en),
    .wdata      (wdata_q),
    .rd_word    (rd_word),
    .rd_byte    (rd_byte),
    .wr_sel     (bus.dcache_wr_sel),
    .wr_line    (bus.dcache_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LDR;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    wr_en           = 1'b0;
    bus.ready       = 1'b0;
    bus.done        = 1'b0;
    bus.dcache_req  = 1'b0;
    bus.dcache_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          op_d    = lc3b_mem_op'(bus.op);
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          state_d = op_is_indirect(lc3b_mem_op'(bus.op)) ? ST_PTR : ST_MEM;
        end
      end
      ST_PTR: begin
        bus.dcache_req  = 1'b1;
        bus.dcache_addr = {addr_q[15:1], 1'b0};
        if (bus.dcache_resp) begin
          addr_d  = rd_word & 16'hFFFE;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        bus.dcache_req  = 1'b1;
        wr_en           = op_is_store(op_q);
        bus.dcache_addr = op_is_byte(op_q) ? addr_q : {addr_q[15:1], 1'b0};
        if (bus.dcache_resp) begin
          if (!op_is_store(op_q)) rdata_d = op_is_byte(op_q) ? {8'h00, rd_byte} : rd_word;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rdata        = rdata_q;
  assign bus.dcache_wr_en = wr_en;

endmodule
